// File: rtl/bcd_updown_counter_pkg.sv
// Shared BCD constants and helpers for the up/down decade counter.
package bcd_updown_counter_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    function automatic logic bcd_invalid(input logic [BCD_W-1:0] d);
        return d > BCD_MAX;
    endfunction

    function automatic logic [BCD_W-1:0] bcd_sanitize(input logic [BCD_W-1:0] d);
        return bcd_invalid(d) ? BCD_MIN : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: loads, increments or decrements, and ripples carry/borrow onward.
module bcd_digit
    import bcd_updown_counter_pkg::*;
#(
    parameter logic [3:0] RST_VAL = 4'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_in,
    input  logic             up,
    input  logic             load,
    input  logic [BCD_W-1:0] load_digit,
    output logic [BCD_W-1:0] digit,
    output logic             step_out
);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;
    logic             at_wrap;

    assign at_wrap  = up ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);
    assign step_out = step_in & at_wrap;
    assign digit    = digit_q;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = bcd_sanitize(load_digit);
        end else if (step_in) begin
            if (up) begin
                digit_d = at_wrap ? BCD_MIN : digit_q + 4'd1;
            end else begin
                digit_d = at_wrap ? BCD_MAX : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            digit_q <= RST_VAL;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-decade BCD up/down counter with parallel load and invalid-digit flagging.
module bcd_updown_counter
    import bcd_updown_counter_pkg::*;
#(
    parameter int unsigned          DIGITS = 4,
    parameter logic [4*DIGITS-1:0]  START  = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    up,
    input  logic                    load,
    input  logic [4*DIGITS-1:0]     load_val,
    output logic [4*DIGITS-1:0]     count,
    output logic                    tc,
    output logic                    load_err
);

    logic [DIGITS:0] step;
    logic            any_invalid;
    logic            load_err_q;

    // Digit 0 steps only when counting; a pending load suppresses the whole chain.
    assign step[0] = en & ~load;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit #(
            .RST_VAL (START[i*BCD_W +: BCD_W])
        ) u_digit (
            .clk        (clk),
            .reset      (reset),
            .step_in    (step[i]),
            .up         (up),
            .load       (load),
            .load_digit (load_val[i*BCD_W +: BCD_W]),
            .digit      (count[i*BCD_W +: BCD_W]),
            .step_out   (step[i+1])
        );
    end

    // The last carry/borrow is high exactly when every digit sits at the wrap point.
    assign tc = reset & step[DIGITS];

    always_comb begin
        any_invalid = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            any_invalid = any_invalid | bcd_invalid(load_val[i*BCD_W +: BCD_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load & any_invalid;
        end
    end

    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for the two-decade BCD counter, plus a START=42 instance for reset value.
module tb_bcd_updown_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       tc;
    logic       load_err;
    logic [7:0] count42;
    logic       tc42;
    logic       load_err42;

    int n_tests;
    int n_fail;

    bcd_updown_counter #(
        .DIGITS (2),
        .START  (8'h00)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .load_err (load_err)
    );

    bcd_updown_counter #(
        .DIGITS (2),
        .START  (8'h42)
    ) dut42 (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count42),
        .tc       (tc42),
        .load_err (load_err42)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    initial begin
        int v;
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b0;
        en       = 1'b1;
        up       = 1'b0;
        load     = 1'b0;
        load_val = 8'h00;
        #2;

        // Scenario 1: reset, then 100 up steps with wrap.
        tick();
        tick();
        check("rst_count", count, 8'h00);
        check("rst_load_err", 8'(load_err), 8'h00);
        check("rst_tc_gated", 8'(tc), 8'h00);
        check("rst_count42", count42, 8'h42);
        reset = 1'b1;
        up    = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            check("up_count", count, to_bcd(i));
            check("up_tc", 8'(tc), 8'(i == 99));
            tick();
        end
        check("up_wrap", count, 8'h00);

        // Scenario 2: load 10, count down through 00 to 99.
        en       = 1'b0;
        load     = 1'b1;
        load_val = 8'h10;
        tick();
        check("ld10_count", count, 8'h10);
        check("ld10_err", 8'(load_err), 8'h00);
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b0;
        for (int i = 0; i < 12; i++) begin
            v = (10 - i + 100) % 100;
            #1;
            check("dn_count", count, to_bcd(v));
            check("dn_tc", 8'(tc), 8'(v == 0));
            if (i < 11) tick();
        end

        // Scenario 3: invalid load beats en; tc masked by load even at 99 counting up.
        up       = 1'b1;
        load     = 1'b1;
        load_val = 8'h3C;
        #1;
        check("ld_tc_masked", 8'(tc), 8'h00);
        tick();
        check("ld3c_count", count, 8'h30);
        check("ld3c_err", 8'(load_err), 8'h01);
        load = 1'b0;
        en   = 1'b0;
        tick();
        check("ld3c_err_clr", 8'(load_err), 8'h00);
        check("ld3c_hold", count, 8'h30);
        load     = 1'b1;
        load_val = 8'hA7;
        tick();
        check("lda7_count", count, 8'h07);
        check("lda7_err", 8'(load_err), 8'h01);
        load_val = 8'hFF;
        tick();
        check("ldff_count", count, 8'h00);
        check("ldff_err", 8'(load_err), 8'h01);

        // Scenario 4: reset mid-count aborts step and restarts from START.
        load_val = 8'h00;
        tick();
        check("ld00_err", 8'(load_err), 8'h00);
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("pre_rst", count, 8'h05);
        reset = 1'b0;
        tick();
        check("mid_rst", count, 8'h00);
        reset = 1'b1;
        tick();
        check("post_rst", count, 8'h01);

        // Scenario 5: direction toggles take effect immediately.
        en       = 1'b0;
        load     = 1'b1;
        load_val = 8'h19;
        tick();
        check("ld19", count, 8'h19);
        load = 1'b0;
        en   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            up = (i % 2 == 0);
            #1;
            check("tog_tc", 8'(tc), 8'h00);
            tick();
            check("tog_count", count, (i % 2 == 0) ? 8'h20 : 8'h19);
        end

        // Scenario 6: START=42 instance reset and hold.
        reset = 1'b0;
        tick();
        check("s42_rst", count42, 8'h42);
        reset = 1'b1;
        en    = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("s42_hold", count42, 8'h42);
        check("s42_main_hold", count, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of BCD decades (legal range 1-8).
REQ-002 The block SHALL have parameter START, default 0, giving the packed BCD reset value of count; every nibble SHALL be 0-9.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset).
REQ-005 en  input  1  count enable; one step per clk edge while high.
REQ-006 up  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous parallel load request.
REQ-008 load_val  input  4*DIGITS  packed BCD load value; digit 0 in bits [3:0].
REQ-009 count  output  4*DIGITS  registered packed BCD count; digit 0 is least significant.
REQ-010 tc  output  1  combinational terminal count: high when en=1, load=0, and count is at the wrap point for the current direction.
REQ-011 load_err  output  1  registered flag: high for one cycle after a load that contained any nibble greater than 9.

Function
REQ-012 Priority per edge SHALL be: reset, then load, then en; with none active, count SHALL hold.
REQ-013 Up-count: digit 0 SHALL increment; a digit at 9 SHALL wrap to 0 and carry into the next digit in the same cycle.
REQ-014 Down-count: digit 0 SHALL decrement; a digit at 0 SHALL wrap to 9 and borrow from the next digit in the same cycle.
REQ-015 Whole-counter wrap: all-9s up SHALL go to all-0s; all-0s down SHALL go to all-9s. No sticky overflow state.
REQ-016 tc SHALL equal en & ~load & (up ? all digits 9 : all digits 0); it SHALL be high in exactly the cycle before the wrap edge.
REQ-017 Load SHALL take effect on the next edge (latency 1); each valid nibble (0-9) SHALL load unchanged.
REQ-018 An invalid nibble (10-15) in load_val SHALL load as 0 in that digit; the valid digits SHALL still load.
REQ-019 load_err SHALL be set on the edge that performs a load containing any invalid nibble, and cleared on every other edge.
REQ-020 The direction change SHALL take effect on the first edge after up toggles; there is no pipeline delay.
REQ-021 count SHALL never hold a nibble greater than 9 in any cycle after reset.

Reset
REQ-022 When reset=0 at a rising edge, count SHALL become START and load_err SHALL become 0, regardless of en and load.
REQ-023 Reset during counting SHALL abort the step; counting SHALL resume from START on the first edge with reset=1 and en=1.
REQ-024 tc SHALL be 0 while reset=0 in the same cycle. Gate tc with reset to meet this.

Structure
REQ-025 The shared package/header SHALL define BCD_W=4, BCD_MAX=4'd9, and BCD_MIN=4'd0.
REQ-026 One sub-module, bcd_digit, SHALL implement one decade, with these ports:
- inputs: clk, reset, step_in, up, load, load_digit
- outputs: digit, step_out (carry/borrow)
REQ-027 The top SHALL instantiate DIGITS bcd_digit instances with a generate loop, chaining step_out into the next step_in.
REQ-028 step_in of digit 0 SHALL be en & ~load.
REQ-029 The carry chain SHALL be combinational (ripple), giving single-cycle multi-digit carry.

Verification (DIGITS=2, START=0 unless stated)
REQ-030 Scenario 1: reset=0 for 2 edges, then en=1, up=1 for 100 edges.
- count SHALL read 00,01,...,09,10,...,99, then 00.
- tc SHALL be high only while count=99.
REQ-031 Scenario 2: load 8'h10, then en=1, up=0.
- count SHALL read 10,09,08,...,00, then 99.
- tc SHALL be high only while count=00.
REQ-032 Scenario 3: load 8'h3C with en=1 in the same cycle.
- The next count SHALL be 30 (no count step that cycle).
- load_err SHALL be 1 for exactly one cycle.
REQ-033 Scenario 4: count up from 00; at count=05 drive reset=0 for 1 edge with en=1.
- count SHALL be 00 (START) after that edge.
- The next edge with reset=1 SHALL give 01.
REQ-034 Scenario 5: at count=19 with up=1, toggle up each cycle.
- count SHALL read 19,20,19,20; tc SHALL stay 0.
REQ-035 Scenario 6: START=8'h42, then reset.
- count SHALL read 42.
- After en=0 for 5 edges, count SHALL still read 42.
